// File: rtl/instruction_fetch.sv
// IF stage: program counter, instruction memory and IF/ID register.
// Handles stall, branch/jump redirect, HALT and the debug loader port.
module instruction_fetch #(
    parameter int NB_PC         = 32,
    parameter int NB_INSTR      = 32,
    parameter int N_INSN_WORDS  = 256,
    parameter int NB_OPCODE     = 6,
    parameter int NB_INDEX_REG  = 5,
    parameter int NB_SHAMT      = 5,
    parameter int NB_FUNC       = 6,
    parameter int NB_OFFSET     = 16,
    parameter int NB_ADDR_INDEX = 26,
    parameter logic [NB_INSTR-1:0] HALT_WORD = 32'hFFFF_FFFF,
    localparam int NB_WADDR     = $clog2(N_INSN_WORDS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pipe_enabled,
    input  logic                     i_stall,
    input  logic                     i_branch_taken,
    input  logic [NB_PC-1:0]         i_branch_target,
    input  logic                     i_jump,
    input  logic [NB_PC-1:0]         i_jump_target,
    input  logic                     i_mem_write_enable,
    input  logic [NB_WADDR-1:0]      i_mem_write_addr,
    input  logic [NB_INSTR-1:0]      i_mem_write_data,
    output logic [NB_OPCODE-1:0]     o_opcode,
    output logic [NB_INDEX_REG-1:0]  o_index_reg_rs,
    output logic [NB_INDEX_REG-1:0]  o_index_reg_rt,
    output logic [NB_INDEX_REG-1:0]  o_index_reg_rd,
    output logic [NB_SHAMT-1:0]      o_shift_amount,
    output logic [NB_FUNC-1:0]       o_func,
    output logic [NB_OFFSET-1:0]     o_offset,
    output logic [NB_ADDR_INDEX-1:0] o_addr_index,
    output logic [NB_PC-1:0]         o_pc_plus4,
    output logic [NB_PC-1:0]         o_pc,
    output logic                     o_halt
);

    logic [NB_INSTR-1:0] mem [N_INSN_WORDS];

    logic [NB_PC-1:0]    pc;
    logic [NB_PC-1:0]    pc_next;
    logic [NB_PC-1:0]    pc_plus4;
    logic [NB_PC-1:0]    ifid_pc4;
    logic [NB_PC-1:0]    ifid_pc4_next;
    logic [NB_INSTR-1:0] ifid_word;
    logic [NB_INSTR-1:0] ifid_word_next;
    logic [NB_INSTR-1:0] fetch_word;
    logic                halted;
    logic                halted_next;

    // Upper PC bits are ignored, so fetch wraps around the memory.
    assign fetch_word = mem[pc[NB_WADDR+1:2]];
    assign pc_plus4   = pc + NB_PC'(4);

    always_ff @(posedge i_clk) begin
        if (i_mem_write_enable)
            mem[i_mem_write_addr] <= i_mem_write_data;
    end

    always_comb begin
        pc_next        = pc;
        ifid_word_next = ifid_word;
        ifid_pc4_next  = ifid_pc4;
        halted_next    = halted;
        if (i_pipe_enabled) begin
            if (i_branch_taken) begin
                pc_next        = i_branch_target;
                ifid_word_next = '0;
                ifid_pc4_next  = '0;
                halted_next    = 1'b0;
            end else if (i_jump) begin
                pc_next        = i_jump_target;
                ifid_word_next = '0;
                ifid_pc4_next  = '0;
                halted_next    = 1'b0;
            end else if (i_stall) begin
                pc_next        = pc;
            end else if (halted) begin
                ifid_word_next = '0;
                ifid_pc4_next  = '0;
            end else if (fetch_word == HALT_WORD) begin
                ifid_word_next = HALT_WORD;
                ifid_pc4_next  = pc_plus4;
                halted_next    = 1'b1;
            end else begin
                pc_next        = pc_plus4;
                ifid_word_next = fetch_word;
                ifid_pc4_next  = pc_plus4;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc        <= '0;
            ifid_word <= '0;
            ifid_pc4  <= '0;
            halted    <= 1'b0;
        end else begin
            pc        <= pc_next;
            ifid_word <= ifid_word_next;
            ifid_pc4  <= ifid_pc4_next;
            halted    <= halted_next;
        end
    end

    assign o_opcode       = ifid_word[31:26];
    assign o_index_reg_rs = ifid_word[25:21];
    assign o_index_reg_rt = ifid_word[20:16];
    assign o_index_reg_rd = ifid_word[15:11];
    assign o_shift_amount = ifid_word[10:6];
    assign o_func         = ifid_word[5:0];
    assign o_offset       = ifid_word[15:0];
    assign o_addr_index   = ifid_word[25:0];
    assign o_pc_plus4     = ifid_pc4;
    assign o_pc           = pc;
    assign o_halt         = halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: scripted steps with a scoreboard queue
// of expected PC / IF/ID state per clock edge.
module tb_instruction_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pipe_enabled = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic [31:0] i_branch_target = '0;
    logic        i_jump = 1'b0;
    logic [31:0] i_jump_target = '0;
    logic        i_mem_write_enable = 1'b0;
    logic [7:0]  i_mem_write_addr = '0;
    logic [31:0] i_mem_write_data = '0;
    logic [5:0]  o_opcode;
    logic [4:0]  o_index_reg_rs;
    logic [4:0]  o_index_reg_rt;
    logic [4:0]  o_index_reg_rd;
    logic [4:0]  o_shift_amount;
    logic [5:0]  o_func;
    logic [15:0] o_offset;
    logic [25:0] o_addr_index;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_pc;
    logic        o_halt;

    instruction_fetch dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_pipe_enabled     (i_pipe_enabled),
        .i_stall            (i_stall),
        .i_branch_taken     (i_branch_taken),
        .i_branch_target    (i_branch_target),
        .i_jump             (i_jump),
        .i_jump_target      (i_jump_target),
        .i_mem_write_enable (i_mem_write_enable),
        .i_mem_write_addr   (i_mem_write_addr),
        .i_mem_write_data   (i_mem_write_data),
        .o_opcode           (o_opcode),
        .o_index_reg_rs     (o_index_reg_rs),
        .o_index_reg_rt     (o_index_reg_rt),
        .o_index_reg_rd     (o_index_reg_rd),
        .o_shift_amount     (o_shift_amount),
        .o_func             (o_func),
        .o_offset           (o_offset),
        .o_addr_index       (o_addr_index),
        .o_pc_plus4         (o_pc_plus4),
        .o_pc               (o_pc),
        .o_halt             (o_halt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic [31:0] pc4;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ifid_word();
        return {o_opcode, o_addr_index};
    endfunction

    // Drive one cycle of stimulus, queue the expected result, then
    // compare against the DUT just after the edge.
    task automatic step(input string tag, input logic en, input logic st,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt,
                        input logic we, input logic [7:0] wa,
                        input logic [31:0] wd,
                        input logic [31:0] e_pc, input logic [31:0] e_word,
                        input logic [31:0] e_pc4, input logic e_halt);
        exp_t e;
        i_pipe_enabled     = en;
        i_stall            = st;
        i_branch_taken     = br;
        i_branch_target    = bt;
        i_jump             = jp;
        i_jump_target      = jt;
        i_mem_write_enable = we;
        i_mem_write_addr   = wa;
        i_mem_write_data   = wd;
        sb.push_back('{e_pc, e_word, e_pc4, e_halt});
        @(posedge i_clk);
        #1;
        i_mem_write_enable = 1'b0;
        e = sb.pop_front();
        check({tag, ".pc"}, o_pc, e.pc);
        check({tag, ".word"}, ifid_word(), e.word);
        check({tag, ".pc4"}, o_pc_plus4, e.pc4);
        check({tag, ".halt"}, {31'd0, o_halt}, {31'd0, e.halt});
    endtask

    task automatic run(input string tag, input logic [31:0] e_pc,
                       input logic [31:0] e_word, input logic [31:0] e_pc4,
                       input logic e_halt);
        step(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, e_pc, e_word, e_pc4, e_halt);
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        i_pipe_enabled     = 1'b0;
        i_mem_write_enable = 1'b1;
        i_mem_write_addr   = a;
        i_mem_write_data   = d;
        @(posedge i_clk);
        #1;
        i_mem_write_enable = 1'b0;
    endtask

    localparam logic [31:0] W0 = 32'h2001_0005;
    localparam logic [31:0] W1 = 32'h2002_0007;
    localparam logic [31:0] W2 = 32'h0022_1820;
    localparam logic [31:0] HW = 32'hFFFF_FFFF;

    initial begin
        #2;
        check("rst.pc", o_pc, 32'd0);
        check("rst.word", ifid_word(), 32'd0);
        check("rst.pc4", o_pc_plus4, 32'd0);
        check("rst.halt", {31'd0, o_halt}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        for (int i = 0; i < 256; i++)
            load(8'(i), 32'h1000_0000 | 32'(i));
        load(8'd0, W0);
        load(8'd1, W1);
        load(8'd2, W2);
        load(8'd3, 32'h0);
        load(8'h10, 32'hAAAA_0001);
        load(8'h11, 32'hAAAA_0002);

        run("f0", 32'd4, W0, 32'd4, 0);
        check("f0.opcode", 32'(o_opcode), 32'h08);
        check("f0.rt", 32'(o_index_reg_rt), 32'd1);
        check("f0.offset", 32'(o_offset), 32'd5);
        run("f1", 32'd8, W1, 32'd8, 0);
        run("f2", 32'd12, W2, 32'd12, 0);
        check("f2.rs", 32'(o_index_reg_rs), 32'd1);
        check("f2.rd", 32'(o_index_reg_rd), 32'd3);
        check("f2.func", 32'(o_func), 32'h20);
        run("f3", 32'd16, 32'd0, 32'd16, 0);

        step("jmp0", 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0);
        run("s0", 32'd4, W0, 32'd4, 0);
        run("s1", 32'd8, W1, 32'd8, 0);
        step("stl0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'd8, W1, 32'd8, 0);
        step("stl1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'd8, W1, 32'd8, 0);
        run("rel", 32'd12, W2, 32'd12, 0);

        step("brpri", 1, 1, 1, 32'h40, 1, 32'h80, 0, 0, 0,
             32'h40, 32'd0, 32'd0, 0);
        run("br1", 32'h44, 32'hAAAA_0001, 32'h44, 0);

        step("dis0", 0, 0, 0, 0, 0, 0, 1, 8'd2, HW,
             32'h44, 32'hAAAA_0001, 32'h44, 0);
        step("dis1", 0, 0, 0, 0, 0, 0, 1, 8'hFF, 32'hCCCC_0001,
             32'h44, 32'hAAAA_0001, 32'h44, 0);
        step("dis2", 0, 0, 0, 0, 0, 0, 1, 8'h12, 32'hAAAA_0003,
             32'h44, 32'hAAAA_0001, 32'h44, 0);
        run("mem", 32'h48, 32'hAAAA_0002, 32'h48, 0);
        run("memw", 32'h4C, 32'hAAAA_0003, 32'h4C, 0);

        step("br0", 1, 0, 1, 32'd0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0);
        run("h0", 32'd4, W0, 32'd4, 0);
        run("h1", 32'd8, W1, 32'd8, 0);
        run("hlt", 32'd8, HW, 32'd12, 1);
        run("hdr0", 32'd8, 32'd0, 32'd0, 1);
        run("hdr1", 32'd8, 32'd0, 32'd0, 1);
        step("hbr", 1, 0, 1, 32'd0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0);
        run("hr0", 32'd4, W0, 32'd4, 0);
        run("hr1", 32'd8, W1, 32'd8, 0);
        run("hr2", 32'd8, HW, 32'd12, 1);
        step("hstl", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'd8, HW, 32'd12, 1);

        #2;
        i_rst = 1'b1;
        #1;
        check("arst.pc", o_pc, 32'd0);
        check("arst.word", ifid_word(), 32'd0);
        check("arst.pc4", o_pc_plus4, 32'd0);
        check("arst.halt", {31'd0, o_halt}, 32'd0);
        i_stall = 1'b0;
        @(posedge i_clk);
        #1;
        check("arst.hold", o_pc, 32'd0);
        i_rst = 1'b0;
        run("post", 32'd4, W0, 32'd4, 0);

        step("wr0", 0, 0, 0, 0, 0, 0, 1, 8'd0, 32'hDDDD_0001,
             32'd4, W0, 32'd4, 0);
        step("jwrap", 1, 0, 0, 0, 1, 32'h3FC, 0, 0, 0,
             32'h3FC, 32'd0, 32'd0, 0);
        run("w255", 32'h400, 32'hCCCC_0001, 32'h400, 0);
        run("wrap", 32'h404, 32'hDDDD_0001, 32'h404, 0);
        step("jtop", 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0,
             32'hFFFF_FFFC, 32'd0, 32'd0, 0);
        run("pcwrap", 32'd0, 32'hCCCC_0001, 32'd0, 0);
        step("same", 1, 0, 0, 0, 0, 0, 1, 8'd0, 32'hEEEE_0001,
             32'd4, 32'hDDDD_0001, 32'd4, 0);
        step("jback", 1, 0, 0, 0, 1, 32'd0, 0, 0, 0,
             32'd0, 32'd0, 32'd0, 0);
        run("new", 32'd4, 32'hEEEE_0001, 32'd4, 0);

        check("sb.empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
